// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with sign correction in a final calc cycle.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [5:0]        cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   mb;
  logic [2*XLEN-1:0] acc;
  logic              neg_q;
  logic              neg_r;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Request decode, evaluated against the live inputs while IDLE
  logic            is_div;
  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div      = funct3[2];
    a_sgn       = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn       = is_div ? ~funct3[0] : ~funct3[1];
    a_neg       = a_sgn & operand_a[XLEN-1];
    b_neg       = b_sgn & operand_b[XLEN-1];
    div_zero    = is_div && (operand_b == '0);
    div_ovf     = is_div && !funct3[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? operand_a : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : operand_a;
  end

  // One iteration step: multiply adds the multiplicand into the upper half then shifts
  // right; divide shifts the next dividend bit into the partial remainder and trial-subtracts.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   fin;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mb : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mb};
    div_ge   = ~div_diff[XLEN+1];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    mul_prod = cond_neg64(acc, neg_q);
    fin      = '0;
    if (op[2])
      fin = op[1] ? cond_neg32(acc[2*XLEN-1:XLEN], neg_r) : cond_neg32(acc[XLEN-1:0], neg_q);
    else
      fin = (op[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      mb     <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            mb    <= mag(operand_b, b_sgn);
            acc   <= {{XLEN{1'b0}}, mag(operand_a, a_sgn)};
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        // Counts 0..31 iterate; count 32 applies sign correction and selects the result
        CALC: begin
          if (cnt == 6'(XLEN)) begin
            result <= fin;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= op[2] ? div_next : mul_next;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit with an expected-result queue checked at done.
module tb_rv32m_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  rv32m_muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one request, confirm the previous result is still held, then wait for done.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input int lat);
    int          cyc;
    logic        busy_all;
    logic [31:0] e;
    @(posedge clk);
    #1;
    funct3    = f3;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    chk({tag, " hold"}, result, last_res);
    chk({tag, " idle busy/done"}, {30'b0, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    funct3    = 3'($urandom_range(7, 0));
    cyc       = 0;
    busy_all  = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      busy_all &= busy;
    end while (done !== 1'b1 && cyc < 40);
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " busy"}, {31'b0, busy_all}, 32'd1);
    e = exp_q.pop_front();
    chk({tag, " result"}, result, e);
    last_res = e;
  endtask

  initial begin
    logic saw;
    rst       = 1'b0;
    start     = 1'b0;
    funct3    = 3'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    last_res  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy/done", {30'b0, busy, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    do_op("MUL 7*-3",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    do_op("MULH min*min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    do_op("MULHU max*max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    do_op("MULHSU -1*max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    do_op("MUL zero",        3'b000, 32'd0,        32'h00012345, 32'd0,        34);
    do_op("DIV -7/2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    do_op("REM -7/2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    do_op("REM 7/-2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34);
    do_op("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14,       34);
    do_op("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2,        34);
    do_op("DIVU by zero",    3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1);
    do_op("REMU by zero",    3'b111, 32'h12345678, 32'd0,        32'h12345678, 1);
    do_op("DIV by zero",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
    do_op("DIV overflow",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("REM overflow",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Abort: ignored start at cycle 10, reset at cycle 20
    @(posedge clk);
    #1;
    funct3    = 3'b000;
    operand_a = 32'h00001234;
    operand_b = 32'h00005678;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    funct3    = 3'b101;
    operand_a = 32'd5;
    operand_b = 32'd0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start ignored in CALC", {30'b0, busy, done}, 32'd2);
    repeat (9) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async reset busy/done", {30'b0, busy, done}, 32'd0);
    chk("async reset result", result, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    chk("no done after abort", {31'b0, saw}, 32'd0);
    last_res = 32'd0;
    do_op("DIVU 9/3 after reset", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    do_op("B2B MUL 3*5",   3'b000, 32'd3,  32'd5, 32'd15, 34);
    do_op("B2B DIVU 15/4", 3'b101, 32'd15, 32'd4, 32'd3,  34);

    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
